// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// FSM state encoding, funct3 size codes, exception codes, lane helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } lsuState_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  // Byte-lane strobe for a store of size f3[1:0] at byte offset off.
  function automatic logic [3:0] storeStrb(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      (size == 2'b00): s = 4'b0001 << off;
      (size == 2'b01): s = off[1] ? 4'b1100 : 4'b0011;
      default:         s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_mem_access_load_align.sv
// Extracts the addressed byte/half/word from a read word and extends it.
// Ports: rdata (word), off (ea[1:0]), funct3 (size/sign), data (result).
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    data = '0;
    unique case (1'b1)
      (funct3 == F3_B):  data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      (funct3 == F3_H):  data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      (funct3 == F3_W):  data = lane;
      (funct3 == F3_BU): data = {{(XLEN-8){1'b0}}, lane[7:0]};
      (funct3 == F3_HU): data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default:           data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: effective address, legality check, single-outstanding
// memory request, store lane alignment and load extension. Ports: EX
// request (in_*), memory req/resp (mem_*), one-cycle completion (done_*).
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_base,
  input  logic [XLEN-1:0] in_offset,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [RD_W-1:0] in_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            done_valid,
  output logic            done_wen,
  output logic [RD_W-1:0] done_rd,
  output logic [XLEN-1:0] done_data,
  output logic            done_exc,
  output logic [3:0]      done_exc_code
);

  lsuState_e stateQ, stateD;

  logic            isStoreQ;
  logic [2:0]      f3Q;
  logic [XLEN-1:0] eaQ;
  logic [XLEN-1:0] wdataQ;
  logic [RD_W-1:0] rdQ;
  logic            excQ;
  logic [3:0]      excCodeQ;
  logic [XLEN-1:0] resultQ;

  logic            accept;
  logic            illegal;
  logic            misalign;
  logic            inReq;
  logic            inDone;
  logic [3:0]      strb;
  logic [XLEN-1:0] laneData;
  logic [XLEN-1:0] loadData;

  assign in_ready = (stateQ == IDLE);
  assign accept   = in_valid && in_ready;
  assign inReq    = (stateQ == REQ);
  assign inDone   = (stateQ == DONE);

  // Stores only use B/H/W; loads additionally allow BU/HU.
  assign illegal = isStoreQ ? f3Q[2]
                 : (f3Q == 3'b011) || (f3Q[2:1] == 2'b11);

  assign misalign = (f3Q[1:0] == 2'b01) ? eaQ[0]
                  : (f3Q[1:0] == 2'b10) ? (eaQ[1:0] != 2'b00)
                  : 1'b0;

  assign strb = storeStrb(f3Q[1:0], eaQ[1:0]);

  always_comb begin
    laneData = wdataQ;
    unique case (1'b1)
      (f3Q[1:0] == 2'b00): laneData = {4{wdataQ[7:0]}};
      (f3Q[1:0] == 2'b01): laneData = {2{wdataQ[15:0]}};
      default:             laneData = wdataQ;
    endcase
  end

  lsu_load_align #(
    .XLEN(XLEN)
  ) uAlign (
    .rdata (mem_rdata),
    .off   (eaQ[1:0]),
    .funct3(f3Q),
    .data  (loadData)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:  if (in_valid) stateD = CHECK;
      CHECK: stateD = (illegal || misalign) ? DONE : REQ;
      REQ:   if (mem_req_ready) stateD = isStoreQ ? DONE : WAIT;
      WAIT:  if (mem_rvalid) stateD = DONE;
      DONE:  stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isStoreQ <= 1'b0;
      f3Q      <= '0;
      eaQ      <= '0;
      wdataQ   <= '0;
      rdQ      <= '0;
      excQ     <= 1'b0;
      excCodeQ <= '0;
      resultQ  <= '0;
    end else begin
      if (accept) begin
        isStoreQ <= in_is_store;
        f3Q      <= in_funct3;
        eaQ      <= in_base + in_offset;
        wdataQ   <= in_wdata;
        rdQ      <= in_rd;
        excQ     <= 1'b0;
        excCodeQ <= '0;
        resultQ  <= '0;
      end
      if (stateQ == CHECK) begin
        if (illegal) begin
          excQ     <= 1'b1;
          excCodeQ <= EXC_ILLEGAL;
        end else if (misalign) begin
          excQ     <= 1'b1;
          excCodeQ <= isStoreQ ? EXC_ST_MISALIGN
                               : EXC_LD_MISALIGN;
        end
      end
      if (stateQ == WAIT && mem_rvalid) begin
        resultQ <= loadData;
      end
    end
  end

  assign mem_req_valid = inReq;
  assign mem_addr  = inReq ? {eaQ[XLEN-1:2], 2'b00} : '0;
  assign mem_we    = inReq && isStoreQ;
  assign mem_wstrb = (inReq && isStoreQ) ? strb : 4'b0000;
  assign mem_wdata = (inReq && isStoreQ) ? laneData : '0;

  assign done_valid    = inDone;
  assign done_wen      = inDone && !isStoreQ && !excQ
                      && (rdQ != '0);
  assign done_rd       = inDone ? rdQ : '0;
  assign done_data     = inDone ? resultQ : '0;
  assign done_exc      = inDone && excQ;
  assign done_exc_code = inDone ? excCodeQ : 4'd0;

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Load/store execution unit that consumes the sign-extended 32-bit load/store offset produced in ID/EX, forms the effective address, and drives a single-outstanding data-memory request/response interface. It also aligns store data into byte lanes and extracts and sign/zero-extends load data for writeback. It sits between the EX stage and the data memory, and returns one completion per accepted operation.

Parameters:
XLEN, 32, data and address width
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  EX presents a load/store
in_ready  out  1  unit can accept an operation (IDLE only)
in_is_store  in  1  1 = store, 0 = load
in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_base  in  XLEN  rs1 value
in_offset  in  XLEN  sign-extended 12-bit load/store offset
in_wdata  in  XLEN  rs2 value (stores)
in_rd  in  RD_W  load destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  word-aligned address ({ea[31:2],2'b00})
mem_we  out  1  write enable
mem_wstrb  out  4  byte-lane strobes
mem_wdata  out  XLEN  lane-aligned store data
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data word
done_valid  out  1  one-cycle completion pulse
done_wen  out  1  register write required
done_rd  out  RD_W  destination register
done_data  out  XLEN  extended load result
done_exc  out  1  exception flag
done_exc_code  out  4  4 = load misaligned, 6 = store misaligned, 2 = illegal funct3

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge): state IDLE. in_ready=1. All other outputs are 0, including mem_req_valid, done_valid and done_exc.
- Effective address ea = in_base + in_offset, modulo 2^32. It is captured with all request fields on the accept cycle (in_valid && in_ready).
- FSM states:
  - IDLE: on accept, go to CHECK.
  - CHECK: evaluate legality and alignment.
    - Illegal funct3: store 1xx, or load 011/110/111. Set exc code 2 and go to DONE.
    - Misaligned: H/HU with ea[0]=1, or W with ea[1:0]!=0. Set exc code 4 (load) or 6 (store) and go to DONE. No memory request is issued.
    - Otherwise go to REQ.
  - REQ: mem_req_valid=1. All mem_* outputs are held stable until mem_req_ready. On handshake, a store goes to DONE and a load goes to WAIT.
  - WAIT: on mem_rvalid, capture the extended result and go to DONE.
  - DONE: done_valid=1 for exactly one cycle, then IDLE.
- Latency (ready/rvalid immediate): load accept at T, req at T+2, rvalid at T+3, done at T+4. Store done at T+3. Exception done at T+2.
- Store lanes:
  - SB: wstrb = 1<<ea[1:0]; byte replicated in all four lanes.
  - SH: wstrb = 0011 (ea[1]=0) or 1100 (ea[1]=1); half replicated in both halves.
  - SW: wstrb = 1111.
  - Loads drive mem_we=0 and wstrb=0000.
- Load extract: lane = mem_rdata >> (8*ea[1:0]); take B/H/W. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- done_wen = load && !exc && rd!=0. done_data is 0 for stores and exceptions.
- mem_rvalid outside WAIT is ignored. mem_req_ready outside REQ is ignored.
- Reset mid-operation: state goes to IDLE and mem_req_valid drops on that edge. Any later mem_rvalid is ignored, and no done_valid is produced.
- in_valid is ignored whenever in_ready=0. in_ready is combinationally (state==IDLE).

Decomposition:
- Package lsu_pkg:
  - state enum {IDLE, CHECK, REQ, WAIT, DONE}
  - funct3 constants F3_B/H/W/BU/HU
  - exception codes EXC_ILLEGAL=2, EXC_LD_MISALIGN=4, EXC_ST_MISALIGN=6
- Sub-module lsu_load_align: combinational extract plus sign/zero-extend from (rdata, ea[1:0], funct3). The FSM, store lane logic and address adder stay in the top.

Test Plan:
- LB, base 0x1000, offset 0xFFFFFFFF (-1), rdata 0x80FF_1234 → mem_addr 0x0FFC, lane 3, done_data 0x0000_0012 is wrong; required 0xFFFF_FF80. done_wen=1 at T+4.
- LHU, ea 0x2002, rdata 0xBEEF_0000 → done_data 0x0000_BEEF. LH on the same data → 0xFFFF_BEEF.
- SB, ea 0x3001, rs2 0x0000_00A5 → mem_we=1, wstrb 0010, wdata 0xA5A5_A5A5. done_valid at T+3 with done_wen=0.
- LW with ea 0x4002 → done_exc=1, code 4, no mem_req_valid pulse. SH with ea 0x4001 → code 6.
- mem_req_ready held low 5 cycles, then rvalid 3 cycles after handshake → mem_addr/mem_we stable throughout, single done_valid pulse.
- rst_n=0 during WAIT, then mem_rvalid=1 → no done_valid, in_ready=1 the cycle after reset releases, next op completes normally.
